// File: rtl/snitch_link_scheduler.sv
// snitch_link_scheduler
// Round-robin arbiter between the Snitch fetch and LSU request ports onto a
// single registered link request, with an in-order origin tag FIFO that routes
// each link response back to the requester that issued it.
//
// Handshake semantics (all ports): a transfer happens in a cycle where valid
// and ready are both high on the rising edge; ready may depend combinationally
// on valid, and valid never depends on ready.
module snitch_link_scheduler #(
    parameter int unsigned AddrWidth      = 8,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1),
    localparam int unsigned StrbWidth     = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // fetch port
    input  logic                 inst_qvalid_i,
    input  logic [AddrWidth-1:0] inst_qaddr_i,
    output logic                 inst_qready_o,
    output logic [DataWidth-1:0] inst_pdata_o,
    output logic                 inst_pvalid_o,
    input  logic                 inst_pready_i,
    // LSU port
    input  logic                 lsu_qvalid_i,
    input  logic [AddrWidth-1:0] lsu_qaddr_i,
    input  logic [DataWidth-1:0] lsu_qdata_i,
    input  logic                 lsu_qwrite_i,
    input  logic [StrbWidth-1:0] lsu_qstrb_i,
    output logic                 lsu_qready_o,
    output logic [DataWidth-1:0] lsu_pdata_o,
    output logic                 lsu_pvalid_o,
    input  logic                 lsu_pready_i,
    // link request (serializer side)
    output logic                 link_qvalid_o,
    output logic [AddrWidth-1:0] link_qaddr_o,
    output logic [DataWidth-1:0] link_qdata_o,
    output logic                 link_qwrite_o,
    output logic [StrbWidth-1:0] link_qstrb_o,
    output logic                 link_qsel_o,
    input  logic                 link_qready_i,
    // link response (deserializer side)
    input  logic                 link_pvalid_i,
    input  logic [DataWidth-1:0] link_pdata_i,
    output logic                 link_pready_o,
    // status
    output logic [CntWidth-1:0]  outstanding_o,
    output logic                 err_o
);

    localparam int unsigned         PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntWidth-1:0] MaxCnt   = CntWidth'(MaxOutstanding);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(MaxOutstanding - 1);

    // Origin encoding used by last_q, the tag FIFO and link_qsel_o.
    localparam logic SelInst = 1'b0;
    localparam logic SelLsu  = 1'b1;

    // Pointers wrap at MaxOutstanding, which need not be a power of two.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // output request register (ORD)
    logic                 ord_valid_q, ord_valid_d;
    logic [AddrWidth-1:0] ord_addr_q, ord_addr_d;
    logic [DataWidth-1:0] ord_data_q, ord_data_d;
    logic                 ord_write_q, ord_write_d;
    logic [StrbWidth-1:0] ord_strb_q, ord_strb_d;
    logic                 ord_sel_q, ord_sel_d;
    logic                 last_q, last_d;

    // tag FIFO and counters
    logic [MaxOutstanding-1:0] tag_q, tag_d;
    logic [PtrWidth-1:0]       wptr_q, wptr_d;
    logic [PtrWidth-1:0]       rptr_q, rptr_d;
    logic [CntWidth-1:0]       fcnt_q, fcnt_d;
    logic [CntWidth-1:0]       outst_q, outst_d;
    logic                      err_q, err_d;

    logic fifo_empty;
    logic head_sel;
    logic resp_hs;
    logic can_load;
    logic issue;
    logic gnt_lsu;
    logic gnt_inst;
    logic req_hs;

    // Response routing: steer the link response to the owner of the oldest tag.
    always_comb begin
        fifo_empty    = (fcnt_q == '0);
        head_sel      = tag_q[rptr_q];
        inst_pdata_o  = link_pdata_i;
        lsu_pdata_o   = link_pdata_i;
        inst_pvalid_o = 1'b0;
        lsu_pvalid_o  = 1'b0;
        link_pready_o = 1'b1;
        if (!fifo_empty) begin
            if (head_sel == SelLsu) begin
                lsu_pvalid_o  = link_pvalid_i;
                link_pready_o = lsu_pready_i;
            end else begin
                inst_pvalid_o = link_pvalid_i;
                link_pready_o = inst_pready_i;
            end
        end
        resp_hs = !fifo_empty && link_pvalid_i && link_pready_o;
    end

    // Arbitration and issue: a retiring response frees its slot in the same cycle.
    always_comb begin
        can_load      = !ord_valid_q || link_qready_i;
        issue         = can_load
                        && ((outst_q < MaxCnt) || resp_hs)
                        && ((fcnt_q < MaxCnt) || resp_hs);
        gnt_lsu       = lsu_qvalid_i && (!inst_qvalid_i || (last_q == SelInst));
        gnt_inst      = inst_qvalid_i && !gnt_lsu;
        inst_qready_o = gnt_inst && issue;
        lsu_qready_o  = gnt_lsu && issue;
        req_hs        = inst_qready_o || lsu_qready_o;
    end

    // ORD next state: load on request handshake, drain on link handshake.
    always_comb begin
        ord_valid_d = ord_valid_q;
        ord_addr_d  = ord_addr_q;
        ord_data_d  = ord_data_q;
        ord_write_d = ord_write_q;
        ord_strb_d  = ord_strb_q;
        ord_sel_d   = ord_sel_q;
        last_d      = last_q;
        if (req_hs) begin
            ord_valid_d = 1'b1;
            ord_addr_d  = gnt_lsu ? lsu_qaddr_i : inst_qaddr_i;
            ord_data_d  = gnt_lsu ? lsu_qdata_i : '0;
            ord_write_d = gnt_lsu && lsu_qwrite_i;
            ord_strb_d  = gnt_lsu ? lsu_qstrb_i : '0;
            ord_sel_d   = gnt_lsu ? SelLsu : SelInst;
            last_d      = gnt_lsu ? SelLsu : SelInst;
        end else if (link_qready_i) begin
            ord_valid_d = 1'b0;
        end
    end

    // Tag FIFO and counter next state; push and pop together leave counts alone.
    always_comb begin
        tag_d   = tag_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        fcnt_d  = fcnt_q;
        outst_d = outst_q;
        err_d   = err_q | (fifo_empty & link_pvalid_i);
        if (req_hs) begin
            tag_d[wptr_q] = gnt_lsu;
            wptr_d        = ptr_inc(wptr_q);
        end
        if (resp_hs) begin
            rptr_d = ptr_inc(rptr_q);
        end
        case ({req_hs, resp_hs})
            2'b10: begin
                fcnt_d  = fcnt_q + 1'b1;
                outst_d = outst_q + 1'b1;
            end
            2'b01: begin
                fcnt_d  = fcnt_q - 1'b1;
                outst_d = outst_q - 1'b1;
            end
            default: begin
                fcnt_d  = fcnt_q;
                outst_d = outst_q;
            end
        endcase
    end

    // State registers; reset empties ORD and the FIFO and makes inst win the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ord_valid_q <= 1'b0;
            ord_addr_q  <= '0;
            ord_data_q  <= '0;
            ord_write_q <= 1'b0;
            ord_strb_q  <= '0;
            ord_sel_q   <= SelInst;
            last_q      <= SelLsu;
            tag_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            fcnt_q      <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            ord_valid_q <= ord_valid_d;
            ord_addr_q  <= ord_addr_d;
            ord_data_q  <= ord_data_d;
            ord_write_q <= ord_write_d;
            ord_strb_q  <= ord_strb_d;
            ord_sel_q   <= ord_sel_d;
            last_q      <= last_d;
            tag_q       <= tag_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            fcnt_q      <= fcnt_d;
            outst_q     <= outst_d;
            err_q       <= err_d;
        end
    end

    // Link request and status outputs come straight from registers.
    always_comb begin
        link_qvalid_o = ord_valid_q;
        link_qaddr_o  = ord_addr_q;
        link_qdata_o  = ord_data_q;
        link_qwrite_o = ord_write_q;
        link_qstrb_o  = ord_strb_q;
        link_qsel_o   = ord_sel_q;
        outstanding_o = outst_q;
        err_o         = err_q;
    end

endmodule

// File: tb/tb_snitch_link_scheduler.sv
// Bench for snitch_link_scheduler: cycle table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_snitch_link_scheduler;

    localparam int MO = 4;
    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    logic        clk_i;
    logic        rst_i;
    logic        inst_qvalid_i;
    logic [7:0]  inst_qaddr_i;
    logic        inst_qready_o;
    logic [31:0] inst_pdata_o;
    logic        inst_pvalid_o;
    logic        inst_pready_i;
    logic        lsu_qvalid_i;
    logic [7:0]  lsu_qaddr_i;
    logic [31:0] lsu_qdata_i;
    logic        lsu_qwrite_i;
    logic [3:0]  lsu_qstrb_i;
    logic        lsu_qready_o;
    logic [31:0] lsu_pdata_o;
    logic        lsu_pvalid_o;
    logic        lsu_pready_i;
    logic        link_qvalid_o;
    logic [7:0]  link_qaddr_o;
    logic [31:0] link_qdata_o;
    logic        link_qwrite_o;
    logic [3:0]  link_qstrb_o;
    logic        link_qsel_o;
    logic        link_qready_i;
    logic        link_pvalid_i;
    logic [31:0] link_pdata_i;
    logic        link_pready_o;
    logic [2:0]  outstanding_o;
    logic        err_o;

    int checks;
    int failures;

    snitch_link_scheduler #(
        .AddrWidth(8),
        .DataWidth(32),
        .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .inst_qvalid_i(inst_qvalid_i),
        .inst_qaddr_i(inst_qaddr_i),
        .inst_qready_o(inst_qready_o),
        .inst_pdata_o(inst_pdata_o),
        .inst_pvalid_o(inst_pvalid_o),
        .inst_pready_i(inst_pready_i),
        .lsu_qvalid_i(lsu_qvalid_i),
        .lsu_qaddr_i(lsu_qaddr_i),
        .lsu_qdata_i(lsu_qdata_i),
        .lsu_qwrite_i(lsu_qwrite_i),
        .lsu_qstrb_i(lsu_qstrb_i),
        .lsu_qready_o(lsu_qready_o),
        .lsu_pdata_o(lsu_pdata_o),
        .lsu_pvalid_o(lsu_pvalid_o),
        .lsu_pready_i(lsu_pready_i),
        .link_qvalid_o(link_qvalid_o),
        .link_qaddr_o(link_qaddr_o),
        .link_qdata_o(link_qdata_o),
        .link_qwrite_o(link_qwrite_o),
        .link_qstrb_o(link_qstrb_o),
        .link_qsel_o(link_qsel_o),
        .link_qready_i(link_qready_i),
        .link_pvalid_i(link_pvalid_i),
        .link_pdata_i(link_pdata_i),
        .link_pready_o(link_pready_o),
        .outstanding_o(outstanding_o),
        .err_o(err_o)
    );

    // clock / reset
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // one cycle: inputs change 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_reset();
        rst_i = 1'b1;
        #1;
        rst_i = 1'b0;
    endtask

    task automatic drive_idle();
        inst_qvalid_i = 1'b0;
        inst_qaddr_i  = '0;
        inst_pready_i = 1'b0;
        lsu_qvalid_i  = 1'b0;
        lsu_qaddr_i   = '0;
        lsu_qdata_i   = '0;
        lsu_qwrite_i  = 1'b0;
        lsu_qstrb_i   = '0;
        lsu_pready_i  = 1'b0;
        link_qready_i = 1'b0;
        link_pvalid_i = 1'b0;
        link_pdata_i  = '0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // cycle table: inputs of one cycle and the outputs expected in that cycle
    typedef struct {
        logic        rst;
        logic        iv;
        logic [7:0]  ia;
        logic        lv;
        logic [7:0]  la;
        logic [31:0] ld;
        logic        lw;
        logic [3:0]  ls;
        logic        qr;
        logic        pv;
        logic [31:0] pd;
        logic        ipr;
        logic        lpr;
        logic        e_iqr;
        logic        e_lqr;
        logic        e_qv;
        logic [7:0]  e_qa;
        logic [31:0] e_qd;
        logic        e_qw;
        logic [3:0]  e_qs;
        logic        e_qsel;
        logic        e_ipv;
        logic        e_lpv;
        logic        e_ppr;
        logic [2:0]  e_out;
        logic        e_err;
    } vec_t;

    localparam int NV = 17;
    vec_t vec [NV];

    // reference model state for the randomized run
    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
        logic        w;
        logic [3:0]  s;
        logic        sel;
    } req_t;

    req_t ord_m[$];
    logic tags_m[$];
    logic last_m;
    logic err_m;

    initial begin
        checks   = 0;
        failures = 0;
        rst_i    = 1'b1;
        drive_idle();
        #12;
        rst_i = 1'b0;

        // reset + idle, single fetch, then a reset and six cycles of contention
        vec[0]  = '{Y,N,8'h00,N,8'h00,32'h0,N,4'h0,N,N,32'h0,N,N, N,N,N,8'h00,32'h0,N,4'h0,N,N,N,Y,3'd0,N};
        vec[1]  = '{N,N,8'h00,N,8'h00,32'h0,N,4'h0,N,N,32'h0,N,N, N,N,N,8'h00,32'h0,N,4'h0,N,N,N,Y,3'd0,N};
        vec[2]  = vec[1];
        vec[3]  = vec[1];
        vec[4]  = vec[1];
        vec[5]  = '{N,Y,8'h10,N,8'h00,32'h0,N,4'h0,Y,N,32'h0,N,N, Y,N,N,8'h00,32'h0,N,4'h0,N,N,N,Y,3'd0,N};
        vec[6]  = '{N,N,8'h00,N,8'h00,32'h0,N,4'h0,Y,N,32'h0,N,N, N,N,Y,8'h10,32'h0,N,4'h0,N,N,N,N,3'd1,N};
        vec[7]  = '{N,N,8'h00,N,8'h00,32'h0,N,4'h0,Y,Y,32'hDEADBEEF,Y,Y, N,N,N,8'h00,32'h0,N,4'h0,N,Y,N,Y,3'd1,N};
        vec[8]  = '{N,N,8'h00,N,8'h00,32'h0,N,4'h0,Y,N,32'h0,N,N, N,N,N,8'h00,32'h0,N,4'h0,N,N,N,Y,3'd0,N};
        vec[9]  = '{Y,Y,8'h30,Y,8'h20,32'hA5A5A5A5,Y,4'h3,Y,N,32'h0,Y,Y, Y,N,N,8'h00,32'h0,N,4'h0,N,N,N,Y,3'd0,N};
        vec[10] = '{N,Y,8'h30,Y,8'h20,32'hA5A5A5A5,Y,4'h3,Y,Y,32'h1111,Y,Y, N,Y,Y,8'h30,32'h0,N,4'h0,N,Y,N,Y,3'd1,N};
        vec[11] = '{N,Y,8'h30,Y,8'h20,32'hA5A5A5A5,Y,4'h3,Y,Y,32'h2222,Y,Y, Y,N,Y,8'h20,32'hA5A5A5A5,Y,4'h3,Y,N,Y,Y,3'd1,N};
        vec[12] = '{N,Y,8'h30,Y,8'h20,32'hA5A5A5A5,Y,4'h3,Y,Y,32'h3333,Y,Y, N,Y,Y,8'h30,32'h0,N,4'h0,N,Y,N,Y,3'd1,N};
        vec[13] = '{N,Y,8'h30,Y,8'h20,32'hA5A5A5A5,Y,4'h3,Y,Y,32'h4444,Y,Y, Y,N,Y,8'h20,32'hA5A5A5A5,Y,4'h3,Y,N,Y,Y,3'd1,N};
        vec[14] = '{N,Y,8'h30,Y,8'h20,32'hA5A5A5A5,Y,4'h3,Y,Y,32'h5555,Y,Y, N,Y,Y,8'h30,32'h0,N,4'h0,N,Y,N,Y,3'd1,N};
        vec[15] = '{N,N,8'h00,N,8'h00,32'h0,N,4'h0,Y,Y,32'h6666,Y,Y, N,N,Y,8'h20,32'hA5A5A5A5,Y,4'h3,Y,N,Y,Y,3'd1,N};
        vec[16] = '{N,N,8'h00,N,8'h00,32'h0,N,4'h0,Y,N,32'h0,N,N, N,N,N,8'h00,32'h0,N,4'h0,N,N,N,Y,3'd0,N};

        for (int i = 0; i < NV; i++) begin
            cyc();
            if (vec[i].rst) pulse_reset();
            inst_qvalid_i = vec[i].iv;
            inst_qaddr_i  = vec[i].ia;
            lsu_qvalid_i  = vec[i].lv;
            lsu_qaddr_i   = vec[i].la;
            lsu_qdata_i   = vec[i].ld;
            lsu_qwrite_i  = vec[i].lw;
            lsu_qstrb_i   = vec[i].ls;
            link_qready_i = vec[i].qr;
            link_pvalid_i = vec[i].pv;
            link_pdata_i  = vec[i].pd;
            inst_pready_i = vec[i].ipr;
            lsu_pready_i  = vec[i].lpr;
            @(negedge clk_i);
            chk($sformatf("v%0d_inst_qready", i), 64'(inst_qready_o), 64'(vec[i].e_iqr));
            chk($sformatf("v%0d_lsu_qready", i), 64'(lsu_qready_o), 64'(vec[i].e_lqr));
            chk($sformatf("v%0d_link_qvalid", i), 64'(link_qvalid_o), 64'(vec[i].e_qv));
            if (vec[i].e_qv) begin
                chk($sformatf("v%0d_link_payload", i),
                    64'({link_qaddr_o, link_qdata_o, link_qwrite_o, link_qstrb_o, link_qsel_o}),
                    64'({vec[i].e_qa, vec[i].e_qd, vec[i].e_qw, vec[i].e_qs, vec[i].e_qsel}));
            end
            chk($sformatf("v%0d_inst_pvalid", i), 64'(inst_pvalid_o), 64'(vec[i].e_ipv));
            chk($sformatf("v%0d_lsu_pvalid", i), 64'(lsu_pvalid_o), 64'(vec[i].e_lpv));
            chk($sformatf("v%0d_pdata", i), 64'({inst_pdata_o, lsu_pdata_o}), 64'({vec[i].pd, vec[i].pd}));
            chk($sformatf("v%0d_link_pready", i), 64'(link_pready_o), 64'(vec[i].e_ppr));
            chk($sformatf("v%0d_outstanding", i), 64'(outstanding_o), 64'(vec[i].e_out));
            chk($sformatf("v%0d_err", i), 64'(err_o), 64'(vec[i].e_err));
        end

        // outstanding limit: the 5th fetch waits, then issues as the first retires
        cyc();
        drive_idle();
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            cyc();
            inst_qvalid_i = 1'b1;
            inst_qaddr_i  = 8'(k);
            link_qready_i = 1'b1;
            @(negedge clk_i);
            chk($sformatf("lim_qready_%0d", k), 64'(inst_qready_o), (k < 4) ? 64'd1 : 64'd0);
            chk($sformatf("lim_out_%0d", k), 64'(outstanding_o), 64'(k));
        end
        cyc();
        link_pvalid_i = 1'b1;
        link_pdata_i  = 32'hCAFE0001;
        inst_pready_i = 1'b1;
        @(negedge clk_i);
        chk("lim_retire_qready", 64'(inst_qready_o), 64'd1);
        chk("lim_retire_pvalid", 64'(inst_pvalid_o), 64'd1);
        cyc();
        inst_qvalid_i = 1'b0;
        link_pvalid_i = 1'b0;
        @(negedge clk_i);
        chk("lim_out_hold", 64'(outstanding_o), 64'd4);
        chk("lim_link_addr", 64'(link_qaddr_o), 64'd4);
        for (int k = 0; k < 4; k++) begin
            cyc();
            link_pvalid_i = 1'b1;
            @(negedge clk_i);
            chk($sformatf("lim_drain_%0d", k), 64'(inst_pvalid_o), 64'd1);
        end
        cyc();
        drive_idle();
        @(negedge clk_i);
        chk("lim_out_empty", 64'(outstanding_o), 64'd0);

        // stalled link holds ORD; ordered responses with a back-pressured first one
        cyc();
        pulse_reset();
        inst_qvalid_i = 1'b1;
        inst_qaddr_i  = 8'h01;
        @(negedge clk_i);
        chk("ord_q1_ready", 64'(inst_qready_o), 64'd1);
        cyc();
        inst_qvalid_i = 1'b0;
        lsu_qvalid_i  = 1'b1;
        lsu_qaddr_i   = 8'h02;
        lsu_qdata_i   = 32'h0000BEEF;
        @(negedge clk_i);
        chk("ord_stall_ready", 64'(lsu_qready_o), 64'd0);
        chk("ord_stall_addr", 64'({link_qvalid_o, link_qaddr_o}), 64'({1'b1, 8'h01}));
        cyc();
        @(negedge clk_i);
        chk("ord_stall_hold", 64'({link_qvalid_o, link_qaddr_o, link_qsel_o}), 64'({1'b1, 8'h01, 1'b0}));
        cyc();
        link_qready_i = 1'b1;
        @(negedge clk_i);
        chk("ord_q2_ready", 64'(lsu_qready_o), 64'd1);
        cyc();
        lsu_qvalid_i  = 1'b0;
        inst_qvalid_i = 1'b1;
        inst_qaddr_i  = 8'h03;
        @(negedge clk_i);
        chk("ord_q3_ready", 64'(inst_qready_o), 64'd1);
        chk("ord_q2_link", 64'({link_qaddr_o, link_qdata_o, link_qsel_o}), 64'({8'h02, 32'h0000BEEF, 1'b1}));
        cyc();
        inst_qvalid_i = 1'b0;
        @(negedge clk_i);
        chk("ord_q3_link", 64'({link_qaddr_o, link_qsel_o}), 64'({8'h03, 1'b0}));
        chk("ord_out3", 64'(outstanding_o), 64'd3);
        for (int k = 0; k < 3; k++) begin
            cyc();
            link_qready_i = 1'b0;
            link_pvalid_i = 1'b1;
            link_pdata_i  = 32'h11110001;
            inst_pready_i = 1'b0;
            lsu_pready_i  = 1'b1;
            @(negedge clk_i);
            chk($sformatf("ord_bp_pready_%0d", k), 64'(link_pready_o), 64'd0);
            chk($sformatf("ord_bp_pvalid_%0d", k), 64'({inst_pvalid_o, lsu_pvalid_o}), 64'({1'b1, 1'b0}));
            chk($sformatf("ord_bp_out_%0d", k), 64'(outstanding_o), 64'd3);
        end
        cyc();
        inst_pready_i = 1'b1;
        @(negedge clk_i);
        chk("ord_r1", 64'({inst_pvalid_o, lsu_pvalid_o, link_pready_o, inst_pdata_o}), 64'({3'b101, 32'h11110001}));
        cyc();
        link_pdata_i  = 32'h22220002;
        inst_pready_i = 1'b0;
        @(negedge clk_i);
        chk("ord_r2", 64'({inst_pvalid_o, lsu_pvalid_o, link_pready_o, lsu_pdata_o}), 64'({3'b011, 32'h22220002}));
        cyc();
        link_pdata_i  = 32'h33330003;
        inst_pready_i = 1'b1;
        lsu_pready_i  = 1'b0;
        @(negedge clk_i);
        chk("ord_r3", 64'({inst_pvalid_o, lsu_pvalid_o, link_pready_o, inst_pdata_o}), 64'({3'b101, 32'h33330003}));
        cyc();
        drive_idle();
        @(negedge clk_i);
        chk("ord_out0", 64'(outstanding_o), 64'd0);

        // stray response with nothing in flight: dropped, sticky error
        cyc();
        link_pvalid_i = 1'b1;
        link_pdata_i  = 32'h0BADF00D;
        @(negedge clk_i);
        chk("stray_pready", 64'(link_pready_o), 64'd1);
        chk("stray_pvalid", 64'({inst_pvalid_o, lsu_pvalid_o}), 64'd0);
        chk("stray_err_before", 64'(err_o), 64'd0);
        cyc();
        link_pvalid_i = 1'b0;
        @(negedge clk_i);
        chk("stray_err_set", 64'(err_o), 64'd1);
        repeat (10) cyc();
        @(negedge clk_i);
        chk("stray_err_sticky", 64'({err_o, outstanding_o}), 64'({1'b1, 3'd0}));
        cyc();
        pulse_reset();
        @(negedge clk_i);
        chk("stray_err_reset", 64'(err_o), 64'd0);

        // randomized run against the reference model, with one mid-run reset
        ord_m.delete();
        tags_m.delete();
        last_m = 1'b1;
        err_m  = 1'b0;
        for (int n = 0; n < 400; n++) begin
            int   inflight;
            logic head;
            logic e_ppr, e_ipv, e_lpv, e_qv, e_iqr, e_lqr;
            logic retire, space, slots, want_lsu;
            req_t r;
            cyc();
            if (n == 200) begin
                pulse_reset();
                ord_m.delete();
                tags_m.delete();
                last_m = 1'b1;
                err_m  = 1'b0;
            end
            inst_qvalid_i = ($urandom_range(0, 9) < 6);
            inst_qaddr_i  = 8'($urandom);
            lsu_qvalid_i  = ($urandom_range(0, 9) < 6);
            lsu_qaddr_i   = 8'($urandom);
            lsu_qdata_i   = $urandom;
            lsu_qwrite_i  = ($urandom_range(0, 1) == 1);
            lsu_qstrb_i   = 4'($urandom_range(0, 15));
            link_qready_i = ($urandom_range(0, 9) < 7);
            link_pdata_i  = $urandom;
            inst_pready_i = ($urandom_range(0, 9) < 7);
            lsu_pready_i  = ($urandom_range(0, 9) < 7);
            link_pvalid_i = (tags_m.size() != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);

            // expected behaviour from the oldest in-flight origin and free room
            inflight = tags_m.size();
            head     = (inflight != 0) ? tags_m[0] : 1'b0;
            e_ppr    = (inflight == 0) ? 1'b1 : (head ? lsu_pready_i : inst_pready_i);
            e_ipv    = (inflight != 0) && !head && link_pvalid_i;
            e_lpv    = (inflight != 0) && head && link_pvalid_i;
            retire   = (inflight != 0) && link_pvalid_i && e_ppr;
            space    = (ord_m.size() == 0) || link_qready_i;
            slots    = ((inflight - (retire ? 1 : 0)) < MO);
            if (inst_qvalid_i && lsu_qvalid_i) want_lsu = !last_m;
            else                               want_lsu = lsu_qvalid_i;
            e_iqr = inst_qvalid_i && !want_lsu && space && slots;
            e_lqr = lsu_qvalid_i && want_lsu && space && slots;
            e_qv  = (ord_m.size() != 0);

            @(negedge clk_i);
            chk("rnd_inst_qready", 64'(inst_qready_o), 64'(e_iqr));
            chk("rnd_lsu_qready", 64'(lsu_qready_o), 64'(e_lqr));
            chk("rnd_link_qvalid", 64'(link_qvalid_o), 64'(e_qv));
            if (e_qv) begin
                chk("rnd_link_payload",
                    64'({link_qaddr_o, link_qdata_o, link_qwrite_o, link_qstrb_o, link_qsel_o}),
                    64'(ord_m[0]));
            end
            chk("rnd_pvalid", 64'({inst_pvalid_o, lsu_pvalid_o}), 64'({e_ipv, e_lpv}));
            chk("rnd_link_pready", 64'(link_pready_o), 64'(e_ppr));
            chk("rnd_outstanding", 64'(outstanding_o), 64'(inflight));
            chk("rnd_err", 64'(err_o), 64'(err_m));

            if (e_qv && link_qready_i) void'(ord_m.pop_front());
            if (e_iqr || e_lqr) begin
                r.a   = want_lsu ? lsu_qaddr_i : inst_qaddr_i;
                r.d   = want_lsu ? lsu_qdata_i : 32'h0;
                r.w   = want_lsu && lsu_qwrite_i;
                r.s   = want_lsu ? lsu_qstrb_i : 4'h0;
                r.sel = want_lsu;
                ord_m.push_back(r);
                tags_m.push_back(want_lsu);
                last_m = want_lsu;
            end
            if (retire) void'(tags_m.pop_front());
            if (inflight == 0 && link_pvalid_i) err_m = 1'b1;
        end

        cyc();
        drive_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
